// File: rtl/hangman_uart_rx.sv
// hangman_uart_rx: 8N1 UART receiver for the inter-board hangman link.
// Deserialises frames on rx into bytes held behind a valid/ack handshake,
// flags uppercase letters, framing errors and overruns.
// Optional build macro: HANGMAN_UART_RX_PARITY_EN adds an even-parity bit
// between data bit 7 and the stop bit, plus a parity_err pulse output.
// CLKS_PER_BIT must be >= 4.
module hangman_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       is_letter,
    output logic       frame_err,
    output logic       overrun,
`ifdef HANGMAN_UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef HANGMAN_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;
    logic          sync1_q, sync1_d;
    logic          rxs_q, rxs_d;
    logic          commit;
    logic          ack;
`ifdef HANGMAN_UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          parity_err_q, parity_err_d;
`endif

    assign ack = data_ack && data_valid_q;

    // Next-state logic: synchroniser, bit timing FSM, output register and handshake
    always_comb begin
        sync1_d      = rx;
        rxs_d        = sync1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        frame_err_d  = 1'b0;
        commit       = 1'b0;
`ifdef HANGMAN_UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rxs_q;
                    if (bit_idx_q == 3'd7) begin
`ifdef HANGMAN_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef HANGMAN_UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d        = '0;
                    par_bad_d    = (^shift_q) ^ rxs_q;
                    parity_err_d = (^shift_q) ^ rxs_q;
                    state_d      = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
`ifdef HANGMAN_UART_RX_PARITY_EN
                        commit = !par_bad_q;
`else
                        commit = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An ack on the commit cycle frees the register for the new byte
        if (ack) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end
        if (commit) begin
            if (!data_valid_q || ack) begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State registers with synchronous reset; synchroniser resets to line idle
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef HANGMAN_UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            rxs_q        <= rxs_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
`ifdef HANGMAN_UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
    assign is_letter  = data_valid_q && (data_q >= 8'h41) && (data_q <= 8'h5A);
`ifdef HANGMAN_UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_hangman_uart_rx.sv
// Scoreboard bench for hangman_uart_rx: directed scenarios plus random bytes.
module tb_hangman_uart_rx;

    localparam int unsigned CPB = 8;
`ifdef HANGMAN_UART_RX_PARITY_EN
    localparam int unsigned LAT = 79 + CPB;
`else
    localparam int unsigned LAT = 79;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       data_ack;
    logic       mon_ack;
    logic       dir_ack;
    logic [7:0] data;
    logic       data_valid;
    logic       is_letter;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef HANGMAN_UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         checks = 0;
    int         errors = 0;
    int         fe_count = 0;
    int         fe_long = 0;
    logic       fe_prev = 1'b0;
    logic       mon_en = 1'b0;
    logic [7:0] exp_q[$];

    assign data_ack = mon_ack | dir_ack;

    always #5 clk = ~clk;

    hangman_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data_ack(data_ack),
        .data(data),
        .data_valid(data_valid),
        .is_letter(is_letter),
        .frame_err(frame_err),
        .overrun(overrun),
`ifdef HANGMAN_UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic letter_of(input logic [7:0] b);
        return (b >= 8'h41) && (b <= 8'h5A);
    endfunction

    // Drives one frame; entered and left just after a rising edge
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
`ifdef HANGMAN_UART_RX_PARITY_EN
        rx = ^b;
        repeat (CPB) @(posedge clk);
        #1;
`endif
        rx = stop;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
        idle_cycles(3);
    endtask

    task automatic dir_ack_pulse();
        dir_ack = 1'b1;
        @(posedge clk);
        #1;
        dir_ack = 1'b0;
    endtask

    // Monitor: consumes each presented byte against the scoreboard and acks it
    initial begin
        mon_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && data_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, data}, 32'h100);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("data", {24'h0, data}, {24'h0, e});
                    check("is_letter", {31'h0, is_letter}, {31'h0, letter_of(e)});
                    check("overrun_clear", {31'h0, overrun}, 32'h0);
                end
                mon_ack = 1'b1;
                @(negedge clk);
                mon_ack = 1'b0;
                check("ack_clears_valid", {31'h0, data_valid}, 32'h0);
            end
        end
    end

    // frame_err pulse counter and width watch
    always @(negedge clk) begin
        if (frame_err) fe_count++;
        if (frame_err && fe_prev) fe_long++;
        fe_prev = frame_err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        dir_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_data", {24'h0, data}, 32'h0);
        check("rst_valid", {31'h0, data_valid}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_is_letter", {31'h0, is_letter}, 32'h0);
        idle_cycles(4);

        // Exact frame-to-commit latency for 'A'
        fork
            send_byte(8'h41, 1'b1);
            begin
                repeat (40) @(posedge clk);
                #1;
                check("busy_mid_frame", {31'h0, busy}, 32'h1);
                repeat (LAT - 41) @(posedge clk);
                #1;
                check("valid_before_latency", {31'h0, data_valid}, 32'h0);
                @(posedge clk);
                #1;
                check("valid_at_latency", {31'h0, data_valid}, 32'h1);
                check("data_A", {24'h0, data}, 32'h41);
                check("is_letter_A", {31'h0, is_letter}, 32'h1);
                check("frame_err_A", {31'h0, frame_err}, 32'h0);
            end
        join
        dir_ack_pulse();
        check("valid_after_ack", {31'h0, data_valid}, 32'h0);
        idle_cycles(3);

        // Back-to-back 'P','E', then '1', consumed by the monitor
        mon_en = 1'b1;
        exp_q.push_back(8'h50);
        send_byte(8'h50, 1'b1);
        exp_q.push_back(8'h45);
        send_byte(8'h45, 1'b1);
        exp_q.push_back(8'h31);
        send_byte(8'h31, 1'b1);
        drain("drain_PE1");

        // Bad stop bit, long break, then recovery with 'L'
        send_byte(8'h55, 1'b0);
        rx = 1'b0;
        idle_cycles(50);
        rx = 1'b1;
        idle_cycles(2 * CPB);
        check("frame_err_pulses", fe_count, 1);
        check("valid_after_frame_err", {31'h0, data_valid}, 32'h0);
        exp_q.push_back(8'h4C);
        send_byte(8'h4C, 1'b1);
        drain("drain_L");

        // Overrun: two frames without ack
        mon_en = 1'b0;
        send_byte(8'h52, 1'b1);
        send_byte(8'h53, 1'b1);
        idle_cycles(4);
        check("overrun_keep_data", {24'h0, data}, 32'h52);
        check("overrun_valid", {31'h0, data_valid}, 32'h1);
        check("overrun_set", {31'h0, overrun}, 32'h1);
        dir_ack_pulse();
        check("overrun_ack_valid", {31'h0, data_valid}, 32'h0);
        check("overrun_ack_clear", {31'h0, overrun}, 32'h0);

        // Ack landing on the commit edge of the next frame
        send_byte(8'h44, 1'b1);
        idle_cycles(2);
        check("held_D", {24'h0, data}, 32'h44);
        fork
            send_byte(8'h5A, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                dir_ack = 1'b1;
                @(posedge clk);
                #1;
                dir_ack = 1'b0;
                check("coincident_data", {24'h0, data}, 32'h5A);
                check("coincident_valid", {31'h0, data_valid}, 32'h1);
                check("coincident_overrun", {31'h0, overrun}, 32'h0);
            end
        join
        dir_ack_pulse();
        check("coincident_cleared", {31'h0, data_valid}, 32'h0);

        // Glitch of two cycles is rejected
        rx = 1'b0;
        idle_cycles(2);
        rx = 1'b1;
        idle_cycles(3);
        check("glitch_busy", {31'h0, busy}, 32'h1);
        idle_cycles(20);
        check("glitch_idle", {31'h0, busy}, 32'h0);
        check("glitch_no_commit", {31'h0, data_valid}, 32'h0);

        // Reset in the middle of a data phase with a byte held
        send_byte(8'h4B, 1'b1);
        idle_cycles(2);
        check("held_K", {31'h0, data_valid}, 32'h1);
        rx = 1'b0;
        idle_cycles(30);
        rst = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_data", {24'h0, data}, 32'h0);
        check("midrst_valid", {31'h0, data_valid}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_letter", {31'h0, is_letter}, 32'h0);
        idle_cycles(4);
        mon_en = 1'b1;
        exp_q.push_back(8'h4F);
        send_byte(8'h4F, 1'b1);
        drain("drain_O");

        // Random bytes with random gaps (zero gap gives back-to-back frames)
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(8'h41, 8'h5A));
            else b = 8'($urandom_range(0, 255));
            idle_cycles($urandom_range(0, 2 * CPB));
            exp_q.push_back(b);
            send_byte(b, 1'b1);
        end
        drain("drain_random");

        check("frame_err_total", fe_count, 1);
        check("frame_err_width", fe_long, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
